// File: rtl/pipo_arb_pkg.sv
// pipo_arb_pkg: shared types, default parameters and helpers for the
// pipo_write_arbiter slice.
//   state_t  : arbiter FSM encoding (IDLE, BUSY)
//   onehot() : index -> one-hot vector, up to MAX_NREQ bits
package pipo_arb_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_NREQ  = 4;
   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned MAX_NREQ  = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Callers truncate the result to their own requester count.
   function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
      onehot = MAX_NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/pipo_write_arbiter_if.sv
// pipo_write_arbiter_if: requester/consumer bundle of the shared holding register.
//   req      : per-requester request
//   data     : flattened request words, slice i = data[i*WIDTH +: WIDTH]
//   gnt      : one-hot grant pulse, one cycle per load
//   q        : shared register contents
//   q_valid  : q holds an unconsumed word
//   q_ready  : consumer accepts q
//   q_src    : index of the requester whose word is in q
//   load_cnt : loads since reset, wraps
// Modports: master = producers/consumer side, slave = arbiter side.
interface pipo_write_arbiter_if import pipo_arb_pkg::*; #(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned NREQ  = DEF_NREQ,
   parameter int unsigned CNT_W = DEF_CNT_W
) ();

   localparam int unsigned IDX_W = $clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      q;
   logic                  q_valid;
   logic                  q_ready;
   logic [IDX_W-1:0]      q_src;
   logic [CNT_W-1:0]      load_cnt;

   modport master (
      output req, data, q_ready,
      input  gnt, q, q_valid, q_src, load_cnt
   );

   modport slave (
      input  req, data, q_ready,
      output gnt, q, q_valid, q_src, load_cnt
   );

endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker. It searches eff_req
// starting at last+1, wraps modulo NREQ, and returns the first set bit.
//   eff_req     : candidate requests
//   last        : index of the previous winner
//   winner_c    : selected index (0 when nothing is pending)
//   any_valid_c : at least one candidate is pending
module rr_priority_pick import pipo_arb_pkg::*; #(
   parameter int unsigned NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         eff_req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [$clog2(NREQ)-1:0] winner_c,
   output logic                    any_valid_c
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   int unsigned      idx;
   logic [IDX_W-1:0] idx_w;

   // Offsets 1..NREQ visit every requester once, ending at last itself.
   always_comb begin
      winner_c    = '0;
      any_valid_c = 1'b0;
      idx         = 0;
      idx_w       = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx   = (32'(last) + off) % NREQ;
         idx_w = IDX_W'(idx);
         if (!any_valid_c && eff_req[idx_w]) begin
            winner_c    = idx_w;
            any_valid_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipo_write_arbiter.sv
// pipo_write_arbiter: shares one WIDTH-bit parallel-in/parallel-out holding
// register between NREQ requesters. It arbitrates round-robin, loads the winner's
// word in parallel, presents the word with a valid/ready handshake, and counts
// the loads.
//   clk : clock
//   rst : asynchronous reset, active low
//   bus : pipo_write_arbiter_if.slave (req/data in, gnt/q/q_valid/q_src/load_cnt
//         out, q_ready in)
// Optional build macro PIPO_ARB_BACK2BACK_EN: a consume in BUSY can reload in
// the same edge, so no IDLE bubble is needed.
module pipo_write_arbiter import pipo_arb_pkg::*; #(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned NREQ  = DEF_NREQ,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input logic                clk,
   input logic                rst,
   pipo_write_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   state_t           state_r, state_n;
   logic [WIDTH-1:0] q_r, q_n;
   logic             q_valid_r, q_valid_n;
   logic [NREQ-1:0]  gnt_r, gnt_n;
   logic [IDX_W-1:0] q_src_r, q_src_n;
   logic [IDX_W-1:0] last_r, last_n;
   logic [CNT_W-1:0] cnt_r, cnt_n;

   logic [NREQ-1:0]  eff_req;
   logic [IDX_W-1:0] winner_c;
   logic             any_valid_c;
   logic             do_load;
   logic [WIDTH-1:0] words [NREQ];

   // Unpack the flattened request words.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign words[g] = bus.data[g*WIDTH +: WIDTH];
   end

   // A requester granted this cycle has not yet seen its grant, so its
   // request is masked.
   assign eff_req = bus.req & ~gnt_r;

   rr_priority_pick #(.NREQ(NREQ)) u_pick (
      .eff_req    (eff_req),
      .last       (last_r),
      .winner_c   (winner_c),
      .any_valid_c(any_valid_c)
   );

   // Compute the next state and the next register values.
   always_comb begin
      state_n   = state_r;
      q_n       = q_r;
      q_valid_n = q_valid_r;
      gnt_n     = '0;
      q_src_n   = q_src_r;
      last_n    = last_r;
      cnt_n     = cnt_r;
      do_load   = 1'b0;

      case (state_r)
         IDLE: begin
            if (any_valid_c) do_load = 1'b1;
         end
         BUSY: begin
            if (bus.q_ready) begin
`ifdef PIPO_ARB_BACK2BACK_EN
               if (any_valid_c) begin
                  do_load = 1'b1;
               end else begin
                  q_valid_n = 1'b0;
                  state_n   = IDLE;
               end
`else
               q_valid_n = 1'b0;
               state_n   = IDLE;
`endif
            end
         end
         default: state_n = IDLE;
      endcase

      if (do_load) begin
         q_n       = words[winner_c];
         q_src_n   = winner_c;
         last_n    = winner_c;
         q_valid_n = 1'b1;
         gnt_n     = NREQ'(onehot(32'(winner_c)));
         cnt_n     = cnt_r + CNT_W'(1);
         state_n   = BUSY;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         q_r       <= '0;
         q_valid_r <= 1'b0;
         gnt_r     <= '0;
         q_src_r   <= '0;
         last_r    <= IDX_W'(NREQ - 1);
         cnt_r     <= '0;
      end else begin
         state_r   <= state_n;
         q_r       <= q_n;
         q_valid_r <= q_valid_n;
         gnt_r     <= gnt_n;
         q_src_r   <= q_src_n;
         last_r    <= last_n;
         cnt_r     <= cnt_n;
      end
   end

   assign bus.q        = q_r;
   assign bus.q_valid  = q_valid_r;
   assign bus.gnt      = gnt_r;
   assign bus.q_src    = q_src_r;
   assign bus.load_cnt = cnt_r;

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// tb_pipo_write_arbiter: directed, table-driven bench for pipo_write_arbiter
// with WIDTH=4, NREQ=4 and CNT_W=3, so the counter wrap is reached quickly.
module tb_pipo_write_arbiter;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned CNT_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nerr = 0;
   int   nchk = 0;

   pipo_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) bus ();

   pipo_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] data;
      logic        q_ready;
      logic [3:0]  gnt;
      logic [3:0]  q;
      logic        v;
      logic [1:0]  src;
      logic [2:0]  cnt;
   } vec_t;

   vec_t tbl [18];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] q,
                          input logic v, input logic [1:0] src, input logic [2:0] cnt);
      chk({tag, " gnt"},      32'(bus.gnt),      32'(g));
      chk({tag, " q"},        32'(bus.q),        32'(q));
      chk({tag, " q_valid"},  32'(bus.q_valid),  32'(v));
      chk({tag, " q_src"},    32'(bus.q_src),    32'(src));
      chk({tag, " load_cnt"}, 32'(bus.load_cnt), 32'(cnt));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      // Round-robin with the consumer always ready, then a backpressured load.
      tbl[0]  = '{4'hF, 16'h4321, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 3'd1};
      tbl[1]  = '{4'hF, 16'h4321, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 3'd1};
      tbl[2]  = '{4'hF, 16'h4321, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 3'd2};
      tbl[3]  = '{4'hF, 16'h4321, 1'b1, 4'h0, 4'h2, 1'b0, 2'd1, 3'd2};
      tbl[4]  = '{4'hF, 16'h4321, 1'b1, 4'h4, 4'h3, 1'b1, 2'd2, 3'd3};
      tbl[5]  = '{4'hF, 16'h4321, 1'b1, 4'h0, 4'h3, 1'b0, 2'd2, 3'd3};
      tbl[6]  = '{4'hF, 16'h4321, 1'b1, 4'h8, 4'h4, 1'b1, 2'd3, 3'd4};
      tbl[7]  = '{4'hF, 16'h4321, 1'b1, 4'h0, 4'h4, 1'b0, 2'd3, 3'd4};
      tbl[8]  = '{4'hF, 16'h4321, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 3'd5};
      tbl[9]  = '{4'hF, 16'h4321, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 3'd5};
      tbl[10] = '{4'h4, 16'h4A21, 1'b0, 4'h4, 4'hA, 1'b1, 2'd2, 3'd6};
      for (int i = 11; i < 16; i++)
         tbl[i] = '{4'h0, 16'h4A21, 1'b0, 4'h0, 4'hA, 1'b1, 2'd2, 3'd6};
      tbl[16] = '{4'h0, 16'h4A21, 1'b1, 4'h0, 4'hA, 1'b0, 2'd2, 3'd6};
      tbl[17] = '{4'h0, 16'h4A21, 1'b1, 4'h0, 4'hA, 1'b0, 2'd2, 3'd6};

      // Reset held with every requester active.
      bus.req     = 4'hF;
      bus.data    = 16'h4321;
      bus.q_ready = 1'b0;
      rst         = 1'b0;
      tick();
      tick();
      chk_all("reset", 4'h0, 4'h0, 1'b0, 2'd0, 3'd0);
      rst = 1'b1;

`ifndef PIPO_ARB_BACK2BACK_EN
      for (int i = 0; i < 18; i++) begin
         bus.req     = tbl[i].req;
         bus.data    = tbl[i].data;
         bus.q_ready = tbl[i].q_ready;
         tick();
         chk_all($sformatf("row%0d", i), tbl[i].gnt, tbl[i].q, tbl[i].v, tbl[i].src, tbl[i].cnt);
      end
`else
      // Consumer always ready: one grant per cycle in rotation.
      bus.q_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_all($sformatf("b2b%0d", k), 4'(4'h1 << (k % 4)), 4'(k % 4 + 1), 1'b1,
                 2'(k % 4), 3'(k + 1));
      end
`endif

      // Asynchronous reset between edges while a word is held.
      do_reset();
      bus.req     = 4'h8;
      bus.data    = 16'h4321;
      bus.q_ready = 1'b0;
      tick();
      chk_all("busy_pre_rst", 4'h8, 4'h4, 1'b1, 2'd3, 3'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 4'h0, 4'h0, 1'b0, 2'd0, 3'd0);
      tick();
      chk("rst_no_gnt", 32'(bus.gnt), 32'h0);
      rst     = 1'b1;
      bus.req = 4'hF;
      tick();
      chk_all("post_rst_prio", 4'h1, 4'h1, 1'b1, 2'd0, 3'd1);

      // Nine loads from requester 0 wrap the 3-bit counter back to 1.
      do_reset();
      bus.req     = 4'h1;
      bus.q_ready = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk($sformatf("wrap%0d gnt", i), 32'(bus.gnt), 32'h1);
         chk($sformatf("wrap%0d cnt", i), 32'(bus.load_cnt), 32'(i % 8));
         tick();
         chk($sformatf("wrap%0d consume", i), 32'(bus.q_valid), 32'h0);
      end
      chk("wrap final", 32'(bus.load_cnt), 32'h1);

      // A request held through its own grant is not granted again immediately.
      bus.req = 4'h2;
      tick();
      chk("mask gnt", 32'(bus.gnt), 32'h2);
      chk("mask q", 32'(bus.q), 32'h2);
      tick();
      chk("mask no regrant", 32'(bus.gnt), 32'h0);
      chk("mask consumed", 32'(bus.q_valid), 32'h0);
      tick();
      chk("mask regrant", 32'(bus.gnt), 32'h2);
      chk("mask regrant cnt", 32'(bus.load_cnt), 32'h3);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
